// File: rtl/stereo_axis_pkg.sv
// Shared types and helpers for the stereo AXI4-Stream frame transmitter.
// Geometry helpers are functions so each instance derives its own constants.
package stereo_axis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

  function automatic int beats_per_line(input int width, input int spc);
    return width / spc;
  endfunction

  function automatic int frame_beats(input int width, input int height, input int spc);
    return (width / spc) * height;
  endfunction

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry output FIFO holding {tuser, tlast, tdata}; entries never move,
// so the head stays stable until it is popped.
module axis_skid_fifo2 #(
  parameter int W = 98
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stereo_axis_frame_tx.sv
// AXI4-Stream video transmitter: reads one frame-buffer word per beat and
// streams frames with tuser on the first beat and tlast at each line end.
module stereo_axis_frame_tx
  import stereo_axis_pkg::*;
#(
  parameter int WIDTH             = 3840,
  parameter int HEIGHT            = 2160,
  parameter int SAMPLES_PER_CLOCK = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int AXIS_TDATA_WIDTH  = SAMPLES_PER_CLOCK * 3 * DATA_WIDTH,
  parameter int LINE_GAP          = 40,
  parameter int ADDR_WIDTH        = 21
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        start,
  input  logic                        continuous,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] mem_rd_data,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);

  localparam int BPL    = beats_per_line(WIDTH, SAMPLES_PER_CLOCK);
  localparam int COL_W  = cnt_width(BPL);
  localparam int ROW_W  = cnt_width(HEIGHT);
  localparam int GAP_W  = cnt_width((LINE_GAP > 1) ? LINE_GAP : 2);
  localparam int FIFO_W = AXIS_TDATA_WIDTH + 2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BPL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((LINE_GAP > 1) ? LINE_GAP - 2 : 0);

  tx_state_e             state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  gap_armed_q, gap_armed_d;
  logic                  inflight_q;
  logic                  tag_user_q;
  logic                  tag_last_q;

  logic [FIFO_W-1:0]     fifo_head;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [2:0]            occ;
  logic                  pop;
  logic                  last_pop;
  logic                  room;
  logic                  eol;
  logic                  eof;
  logic                  gap_release;
  logic                  issue;

  axis_skid_fifo2 #(
    .W (FIFO_W)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (inflight_q),
    .din_i   ({tag_user_q, tag_last_q, mem_rd_data}),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_head;

  assign pop      = ~fifo_empty & m_axis_tready;
  assign last_pop = pop & m_axis_tlast;

  // A beat leaving this cycle frees its slot for a read issued now, which is
  // what lets the stream sustain one beat per clock.
  assign occ  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign room = (occ < 3'd2) & (~fifo_full | pop);

  assign eol = (col_q == COL_LAST);
  assign eof = eol && (row_q == ROW_LAST);

  // The first read after a gap goes out early enough that exactly LINE_GAP
  // idle cycles separate the tlast handshake from the next tvalid.
  always_comb begin
    gap_release = 1'b0;
    if (state_q == GAP) begin
      if (gap_armed_q) begin
        gap_release = (gap_cnt_q == '0);
      end else begin
        gap_release = last_pop && (LINE_GAP == 1);
      end
    end
  end

  assign issue     = ((state_q == RUN) || gap_release) && room;
  assign mem_rd_en = issue;
  assign mem_addr  = addr_q;

  assign frame_done = (state_q == DRAIN) && fifo_empty && !inflight_q;
  assign busy       = (state_q != IDLE) && !(frame_done && !continuous);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    gap_cnt_d   = gap_cnt_q;
    gap_armed_d = gap_armed_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end

      RUN, GAP: begin
        if (state_q == GAP) begin
          if (!gap_armed_q && last_pop && (LINE_GAP > 1)) begin
            gap_armed_d = 1'b1;
            gap_cnt_d   = GAP_LOAD;
          end else if (gap_armed_q && (gap_cnt_q != '0)) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end

        if (issue) begin
          gap_armed_d = 1'b0;
          if (eol) begin
            col_d = '0;
            if (eof) begin
              row_d   = '0;
              addr_d  = '0;
              state_d = DRAIN;
            end else begin
              row_d   = row_q + ROW_W'(1);
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = (LINE_GAP > 0) ? GAP : RUN;
            end
          end else begin
            col_d   = col_q + COL_W'(1);
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = RUN;
          end
        end
      end

      DRAIN: begin
        if (frame_done) begin
          state_d = continuous ? RUN : IDLE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      gap_cnt_q   <= '0;
      gap_armed_q <= 1'b0;
      inflight_q  <= 1'b0;
      tag_user_q  <= 1'b0;
      tag_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      gap_cnt_q   <= gap_cnt_d;
      gap_armed_q <= gap_armed_d;
      inflight_q  <= issue;
      tag_user_q  <= (addr_q == '0);
      tag_last_q  <= eol;
    end
  end

endmodule

// File: tb/tb_stereo_axis_frame_tx.sv
// Directed bench for stereo_axis_frame_tx: an 8x2 frame (2 beats per line)
// run through two instances, one with LINE_GAP=0 and one with LINE_GAP=3.
module tb_stereo_axis_frame_tx;

  localparam int TW = 96;
  localparam int AW = 21;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          m_axis_tready = 1'b1;

  logic          busy0, fdone0, rd0, tv0, tu0, tl0;
  logic [AW-1:0] addr0;
  logic [TW-1:0] rdat0 = '0;
  logic [TW-1:0] td0;
  logic          busy3, fdone3, rd3, tv3, tu3, tl3;
  logic [AW-1:0] addr3;
  logic [TW-1:0] rdat3 = '0;
  logic [TW-1:0] td3;

  always #5 aclk = ~aclk;

  // Frame-buffer model: word content equals its address, one-cycle latency.
  always @(posedge aclk) if (rd0) rdat0 <= TW'(addr0);
  always @(posedge aclk) if (rd3) rdat3 <= TW'(addr3);

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  stereo_axis_frame_tx #(
    .WIDTH(8), .HEIGHT(2), .SAMPLES_PER_CLOCK(4), .DATA_WIDTH(8),
    .AXIS_TDATA_WIDTH(TW), .LINE_GAP(0), .ADDR_WIDTH(AW)
  ) u_dut0 (
    .aclk(aclk), .areset(areset), .start(start), .continuous(continuous),
    .busy(busy0), .frame_done(fdone0), .mem_rd_en(rd0), .mem_addr(addr0),
    .mem_rd_data(rdat0), .m_axis_tvalid(tv0), .m_axis_tdata(td0),
    .m_axis_tuser(tu0), .m_axis_tlast(tl0), .m_axis_tready(m_axis_tready)
  );

  stereo_axis_frame_tx #(
    .WIDTH(8), .HEIGHT(2), .SAMPLES_PER_CLOCK(4), .DATA_WIDTH(8),
    .AXIS_TDATA_WIDTH(TW), .LINE_GAP(3), .ADDR_WIDTH(AW)
  ) u_dut3 (
    .aclk(aclk), .areset(areset), .start(start), .continuous(continuous),
    .busy(busy3), .frame_done(fdone3), .mem_rd_en(rd3), .mem_addr(addr3),
    .mem_rd_data(rdat3), .m_axis_tvalid(tv3), .m_axis_tdata(td3),
    .m_axis_tuser(tu3), .m_axis_tlast(tl3), .m_axis_tready(m_axis_tready)
  );

  typedef struct {
    int data;
    bit user;
    bit last;
    int cyc;
  } beat_t;

  beat_t q0[$];
  beat_t q3[$];
  int    fdc0[$];
  int    fdc3[$];
  bit    fdb0[$];
  bit    fdb3[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Beat capture plus hold-while-stalled checks, sampled mid-cycle.
  logic          stall0 = 1'b0, stall3 = 1'b0;
  logic [TW-1:0] pd0, pd3;
  logic          pu0, pl0, pu3, pl3;

  always @(negedge aclk) begin
    beat_t b;
    if (stall0) begin
      check_eq("hold_valid0", tv0, 1);
      check_eq("hold_data0", td0[63:0], pd0[63:0]);
      check_eq("hold_tags0", {tu0, tl0}, {pu0, pl0});
    end
    if (stall3) begin
      check_eq("hold_valid3", tv3, 1);
      check_eq("hold_data3", td3[63:0], pd3[63:0]);
      check_eq("hold_tags3", {tu3, tl3}, {pu3, pl3});
    end
    if (tv0 && m_axis_tready) begin
      b.data = int'(td0[31:0]); b.user = tu0; b.last = tl0; b.cyc = cyc;
      q0.push_back(b);
    end
    if (tv3 && m_axis_tready) begin
      b.data = int'(td3[31:0]); b.user = tu3; b.last = tl3; b.cyc = cyc;
      q3.push_back(b);
    end
    if (fdone0) begin fdc0.push_back(cyc); fdb0.push_back(busy0); end
    if (fdone3) begin fdc3.push_back(cyc); fdb3.push_back(busy3); end
    stall0 = tv0 && !m_axis_tready && !areset;
    stall3 = tv3 && !m_axis_tready && !areset;
    pd0 = td0; pu0 = tu0; pl0 = tl0;
    pd3 = td3; pu3 = tu3; pl3 = tl3;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1; start = 1'b1;
    @(posedge aclk); #1; start = 1'b0;
  endtask

  task automatic clear_logs();
    q0.delete(); q3.delete();
    fdc0.delete(); fdc3.delete();
    fdb0.delete(); fdb3.delete();
  endtask

  task automatic wait_beats(input int sel, input int n, input int budget);
    int k = 0;
    while (((sel == 0) ? q0.size() : q3.size()) < n && k < budget) begin
      @(negedge aclk); #1;
      k++;
    end
    if (k >= budget)
      check_eq($sformatf("timeout_beats%0d", sel), (sel == 0) ? q0.size() : q3.size(), n);
  endtask

  // One 8x2 frame: data 0..3, tuser on beat 0, tlast on beats 1 and 3.
  task automatic check_frame(input int sel, input string tag);
    beat_t b[$];
    if (sel == 0) b = q0; else b = q3;
    check_eq({tag, "_beats"}, b.size(), 4);
    for (int i = 0; i < b.size() && i < 4; i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), b[i].data, i);
      check_eq($sformatf("%s_user%0d", tag, i), b[i].user, (i == 0) ? 1 : 0);
      check_eq($sformatf("%s_last%0d", tag, i), b[i].last, i % 2);
    end
  endtask

  bit tr_pat [16] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0};

  initial begin
    // Reset state
    tick(3);
    check_eq("rst_tvalid0", tv0, 0);
    check_eq("rst_tvalid3", tv3, 0);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_busy3", busy3, 0);
    check_eq("rst_rd_en0", rd0, 0);
    check_eq("rst_addr0", addr0, 0);
    check_eq("rst_done0", fdone0, 0);
    check_eq("rst_tags0", {tu0, tl0}, 0);
    check_eq("rst_tdata0", td0[63:0], 0);
    areset = 1'b0;
    tick(2);

    // Single frame, tready held high
    clear_logs();
    pulse_start();
    tick(25);
    check_frame(0, "gap0");
    for (int i = 1; i < q0.size() && i < 4; i++)
      check_eq($sformatf("gap0_rate%0d", i), q0[i].cyc - q0[0].cyc, i);
    check_eq("gap0_done_n", fdc0.size(), 1);
    if (fdc0.size() >= 1 && q0.size() == 4)
      check_eq("gap0_done_cyc", fdc0[0], q0[3].cyc + 1);
    check_eq("gap0_busy_end", busy0, 0);
    check_frame(3, "gap3");
    if (q3.size() == 4) begin
      check_eq("gap3_line0_rate", q3[1].cyc - q3[0].cyc, 1);
      check_eq("gap3_idle", q3[2].cyc - q3[1].cyc, 4);
    end
    check_eq("gap3_done_n", fdc3.size(), 1);
    if (fdc3.size() >= 1 && q3.size() == 4)
      check_eq("gap3_done_cyc", fdc3[0], q3[3].cyc + 1);
    check_eq("gap3_busy_end", busy3, 0);

    // Backpressure pattern
    clear_logs();
    @(posedge aclk); #1;
    start = 1'b1;
    m_axis_tready = tr_pat[0];
    for (int i = 1; i < 16; i++) begin
      @(posedge aclk); #1;
      start = 1'b0;
      m_axis_tready = tr_pat[i];
    end
    m_axis_tready = 1'b1;
    tick(30);
    check_frame(0, "bp0");
    check_frame(3, "bp3");

    // Continuous replay, dropped during the second frame
    clear_logs();
    continuous = 1'b1;
    pulse_start();
    wait_beats(0, 5, 60);
    continuous = 1'b0;
    tick(40);
    check_eq("cont_beats", q0.size(), 8);
    for (int i = 0; i < q0.size() && i < 8; i++) begin
      check_eq($sformatf("cont_data%0d", i), q0[i].data, i % 4);
      check_eq($sformatf("cont_user%0d", i), q0[i].user, (i % 4 == 0) ? 1 : 0);
      check_eq($sformatf("cont_last%0d", i), q0[i].last, i % 2);
    end
    check_eq("cont_done_n", fdc0.size(), 2);
    if (fdb0.size() >= 1) check_eq("cont_busy_mid", fdb0[0], 1);
    if (fdb0.size() >= 2) check_eq("cont_busy_last", fdb0[1], 0);
    check_eq("cont_busy_end", busy0, 0);

    // Reset after beat 1, then a fresh frame
    clear_logs();
    pulse_start();
    wait_beats(0, 2, 30);
    areset = 1'b1;
    @(posedge aclk); #1;
    check_eq("mrst_tvalid0", tv0, 0);
    check_eq("mrst_tvalid3", tv3, 0);
    check_eq("mrst_busy0", busy0, 0);
    check_eq("mrst_busy3", busy3, 0);
    check_eq("mrst_rd_en0", rd0, 0);
    check_eq("mrst_addr0", addr0, 0);
    areset = 1'b0;
    tick(3);
    clear_logs();
    pulse_start();
    tick(25);
    check_frame(0, "rst0");
    check_frame(3, "rst3");

    // Start pulses while busy are ignored
    clear_logs();
    pulse_start();
    wait_beats(3, 2, 30);
    pulse_start();
    pulse_start();
    tick(30);
    check_frame(3, "mid3");
    check_eq("mid3_done_n", fdc3.size(), 1);
    check_eq("mid3_busy_end", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
